keypad_hex_entry: RTL
=====================

// Module: keypad_hex_entry
// PURPOSE
//  Scans a 4x4 active-low matrix keypad, debounces presses, and maps each accepted key to a hex nibble.
//  Shifts accepted nibbles into a hex entry register that feeds the 8-digit 7-seg scan driver's HEX_in.
//  It is the input-side counterpart of the display path: the user types digits, and the display shows them.
// PARAMETERS
//  N_DIGITS          4   nibbles held in hex_out; hex_out width = 4*N_DIGITS
//  SCAN_DIV          50000  clock cycles each column stays driven (one "slot")
//  DEBOUNCE_SAMPLES  4   consecutive equal slot samples needed to accept a press or a release
// PORTS
//  clock      in   1           system clock; single clock domain
//  reset      in   1           asynchronous, active-high
//  rows       in   4           keypad rows; active-low (pulled up), asynchronous to clock
//  clear      in   1           sync pulse; zeroes hex_out
//  cols       out  4           keypad column drive; active-low, exactly one bit low
//  key_code   out  4           nibble of the last accepted key
//  key_valid  out  1           1-cycle pulse on each accepted key
//  hex_out    out  4*N_DIGITS  entry register; newest nibble in [3:0]
// BEHAVIOUR
//  Reset values (async, while reset=1):
//   - cols=4'b1110, key_code=0, key_valid=0, hex_out=0
//   - state=SCAN, column index=0, slot/debounce counters=0
//   - rows synchroniser flops=4'b1111
//  Input sync: rows pass through a 2-flop synchroniser, giving rows_s.
//  Slot counter: counts 0..SCAN_DIV-1 and wraps. The sample point is the cycle where count==SCAN_DIV-1.
//  Key map: key_code = MAP[row][col].
//   - row0: 1 2 3 A
//   - row1: 4 5 6 B
//   - row2: 7 8 9 C
//   - row3: E 0 F D
//  Several rows low: the lowest row index wins.
//  FSM states: SCAN, DEBOUNCE, HELD, RELEASE.
//   - SCAN: at the sample point, if rows_s==4'hF, advance the column (0->1->2->3->0) and reset the slot count.
//     Otherwise latch cand={row,col}, set deb_cnt=1, go to DEBOUNCE; the column stays put.
//   - DEBOUNCE: at each sample point, compare the pressed row against cand.
//     Same row: deb_cnt++. When deb_cnt reaches DEBOUNCE_SAMPLES, accept the key and go to HELD.
//     Different row or all released: go to SCAN and advance to the next column.
//   - Accept: on the next clock edge, key_valid=1 for exactly 1 cycle and key_code=MAP[cand].
//     On that same edge, hex_out <= {hex_out[4*N_DIGITS-5:0], key_code}; the oldest nibble drops.
//   - HELD: the column stays put and there is no auto-repeat.
//     At the sample point, rows_s==4'hF sets deb_cnt=1 and goes to RELEASE; otherwise stay in HELD.
//   - RELEASE: at each sample point, all-high increments deb_cnt; any low row goes back to HELD.
//     When deb_cnt reaches DEBOUNCE_SAMPLES, go to SCAN and advance the column.
//  Latency: DEBOUNCE_SAMPLES sample points after the first low sample, plus 1 cycle, to key_valid.
//  clear:
//   - clear=1 sets hex_out=0 on the next edge and does not disturb the FSM.
//   - clear coincident with an accept: clear wins, so hex_out=0. key_valid and key_code still update.
//  Reset mid-operation (any state): immediate return to reset values; a pending key is discarded, no key_valid.
//  key_code holds its value between accepts. key_valid is 0 outside the accept cycle.
// TESTING  (bench uses SCAN_DIV=4, DEBOUNCE_SAMPLES=3, N_DIGITS=4)
//  1. Assert reset mid-run -> cols=1110, hex_out=0x0000, key_valid=0; after release, cols cycle 1110,1101,1011,0111 every 4 clocks.
//  2. Hold key '5' (row1 low while col1 driven) for 20 slots -> exactly one key_valid, key_code=5, hex_out=0x0005.
//  3. Press/release 1,2,3,4, then A -> hex_out 0x1234 after four keys, then 0x234A.
//  4. Key bounces (low 2 samples, high 1, low 1, release) -> no key_valid; the scan resumes with the next column.
//  5. Hold '1' and '7' together (rows 0 and 2, col0) -> key_code=1; after release, hex_out ends in 1.
//  6. Pulse clear in the accept cycle of '9' -> hex_out=0x0000, key_code=9. Assert reset during DEBOUNCE -> no key_valid.

Source files
------------

// File: rtl/keypad_hex_entry.sv
// Scans a 4x4 active-low keypad and debounces presses. Accepted keys are shifted as hex
// nibbles into a small entry register, with the newest nibble in the least significant digit.
module keypad_hex_entry #(
  parameter int unsigned N_DIGITS         = 4,
  parameter int unsigned SCAN_DIV         = 50000,
  parameter int unsigned DEBOUNCE_SAMPLES = 4
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic [3:0]              i_rows,
  input  logic                    i_clear,
  output logic [3:0]              o_cols,
  output logic [3:0]              o_key_code,
  output logic                    o_key_valid,
  output logic [4*N_DIGITS-1:0]   o_hex_out
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  // Two spare codes so the incremented count never wraps before the compare.
  localparam int unsigned DebW = $clog2(DEBOUNCE_SAMPLES + 2);
  localparam logic [CntW-1:0] SlotLast = CntW'(SCAN_DIV - 1);
  localparam logic [DebW-1:0] DebMax   = DebW'(DEBOUNCE_SAMPLES);

  typedef enum logic [1:0] {StScan, StDebounce, StHeld, StRelease} state_e;

  state_e                r_state;
  logic [3:0]            r_rows_m, r_rows_s;
  logic [CntW-1:0]       r_slot_cnt;
  logic [1:0]            r_col;
  logic [3:0]            r_cols;
  logic [1:0]            r_cand_row, r_cand_col;
  logic [DebW-1:0]       r_deb_cnt;
  logic                  r_accept;
  logic                  r_key_valid;
  logic [3:0]            r_key_code;
  logic [4*N_DIGITS-1:0] r_hex;

  logic                  w_sample;
  logic                  w_row_low;
  logic [1:0]            w_row_idx;
  logic [DebW-1:0]       w_deb_inc;
  logic                  w_deb_done;
  logic [3:0]            w_key_map;

  // Two-flop synchroniser for the asynchronous row lines.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_rows_m <= 4'hF;
      r_rows_s <= 4'hF;
    end else begin
      r_rows_m <= i_rows;
      r_rows_s <= r_rows_m;
    end
  end

  // Lowest-numbered low row wins when several keys in a column are down.
  always_comb begin
    w_row_low = (r_rows_s != 4'hF);
    w_row_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!r_rows_s[i]) w_row_idx = 2'(i);
    end
  end

  assign w_sample   = (r_slot_cnt == SlotLast);
  assign w_deb_inc  = r_deb_cnt + 1'b1;
  assign w_deb_done = (w_deb_inc >= DebMax);

  // Keypad legend lookup for the latched candidate key.
  always_comb begin
    w_key_map = 4'h0;
    case ({r_cand_row, r_cand_col})
      4'b0000: w_key_map = 4'h1;
      4'b0001: w_key_map = 4'h2;
      4'b0010: w_key_map = 4'h3;
      4'b0011: w_key_map = 4'hA;
      4'b0100: w_key_map = 4'h4;
      4'b0101: w_key_map = 4'h5;
      4'b0110: w_key_map = 4'h6;
      4'b0111: w_key_map = 4'hB;
      4'b1000: w_key_map = 4'h7;
      4'b1001: w_key_map = 4'h8;
      4'b1010: w_key_map = 4'h9;
      4'b1011: w_key_map = 4'hC;
      4'b1100: w_key_map = 4'hE;
      4'b1101: w_key_map = 4'h0;
      4'b1110: w_key_map = 4'hF;
      4'b1111: w_key_map = 4'hD;
      default: w_key_map = 4'h0;
    endcase
  end

  // Scan/debounce FSM with slot timing, column drive, key outputs and entry register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= StScan;
      r_slot_cnt  <= '0;
      r_col       <= 2'd0;
      r_cols      <= 4'b1110;
      r_cand_row  <= 2'd0;
      r_cand_col  <= 2'd0;
      r_deb_cnt   <= '0;
      r_accept    <= 1'b0;
      r_key_valid <= 1'b0;
      r_key_code  <= 4'h0;
      r_hex       <= '0;
    end else begin
      r_slot_cnt  <= w_sample ? '0 : r_slot_cnt + 1'b1;
      r_key_valid <= r_accept;
      r_accept    <= 1'b0;
      if (r_accept) r_key_code <= w_key_map;
      // Clear beats a coincident shift.
      if (i_clear) begin
        r_hex <= '0;
      end else if (r_accept) begin
        r_hex <= {r_hex[4*N_DIGITS-5:0], w_key_map};
      end

      if (w_sample) begin
        unique case (r_state)
          StScan: begin
            if (!w_row_low) begin
              r_col  <= r_col + 1'b1;
              r_cols <= {r_cols[2:0], r_cols[3]};
            end else begin
              r_cand_row <= w_row_idx;
              r_cand_col <= r_col;
              r_deb_cnt  <= DebW'(1);
              r_state    <= StDebounce;
            end
          end
          StDebounce: begin
            if (w_row_low && (w_row_idx == r_cand_row)) begin
              if (w_deb_done) begin
                r_accept <= 1'b1;
                r_state  <= StHeld;
              end else begin
                r_deb_cnt <= w_deb_inc;
              end
            end else begin
              r_col   <= r_col + 1'b1;
              r_cols  <= {r_cols[2:0], r_cols[3]};
              r_state <= StScan;
            end
          end
          StHeld: begin
            if (!w_row_low) begin
              r_deb_cnt <= DebW'(1);
              r_state   <= StRelease;
            end
          end
          StRelease: begin
            if (w_row_low) begin
              r_state <= StHeld;
            end else if (w_deb_done) begin
              r_col   <= r_col + 1'b1;
              r_cols  <= {r_cols[2:0], r_cols[3]};
              r_state <= StScan;
            end else begin
              r_deb_cnt <= w_deb_inc;
            end
          end
          default: r_state <= StScan;
        endcase
      end
    end
  end

  assign o_cols      = r_cols;
  assign o_key_code  = r_key_code;
  assign o_key_valid = r_key_valid;
  assign o_hex_out   = r_hex;

endmodule
